// File: rtl/seven_seg_mux.sv
// seven_seg_mux
// Time-multiplexed driver for a dual common-anode seven-segment display.
// One active-low segment bus is shared by two digits; the anodes alternate
// SHOW0 -> BLANK0 -> SHOW1 -> BLANK1, with blanking gaps against ghosting.
// Each digit value is latched when its window opens, so a window never tears.
//
// Parameters:
//   DWELL_TICKS  ticks each digit is lit per window (>= 1)
//   BLANK_TICKS  ticks both anodes are off between digits (>= 0, 0 = none)
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-low reset
//   tick    one-cycle pacing strobe (may be held high)
//   digit0  hex value for the right digit (anode an[0])
//   digit1  hex value for the left digit  (anode an[1])
//   seg     segment cathodes, active-low, seg[0]=a .. seg[6]=g (registered)
//   an      anode enables, active-low (registered)
//   frame   one-cycle pulse on entry to SHOW0 (registered)
module seven_seg_mux #(
    parameter int DWELL_TICKS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int MAXLEN = (DWELL_TICKS > BLANK_TICKS)
                          ? ((DWELL_TICKS > 2) ? DWELL_TICKS : 2)
                          : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
    localparam int CW = $clog2(MAXLEN);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS == 0) ? '0 : CW'(BLANK_TICKS - 1);

    localparam logic [1:0] SHOW0  = 2'd0;
    localparam logic [1:0] BLANK0 = 2'd1;
    localparam logic [1:0] SHOW1  = 2'd2;
    localparam logic [1:0] BLANK1 = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    held0_q, held0_d;
    logic [3:0]    held1_q, held1_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          frame_q, frame_d;
    logic          last_tick;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held0_d = held0_q;
        held1_d = held1_q;
        seg_d   = seg_q;
        an_d    = an_q;
        frame_d = 1'b0;

        // With no blanking, a BLANK state (only reachable from reset) ends on
        // the first tick.
        if (state_q == SHOW0 || state_q == SHOW1)
            last_tick = (cnt_q == DWELL_LAST);
        else
            last_tick = (BLANK_TICKS == 0) || (cnt_q == BLANK_LAST);

        if (tick) begin
            if (last_tick) begin
                cnt_d = '0;
                case (state_q)
                    SHOW0:   state_d = (BLANK_TICKS == 0) ? SHOW1 : BLANK0;
                    BLANK0:  state_d = SHOW1;
                    SHOW1:   state_d = (BLANK_TICKS == 0) ? SHOW0 : BLANK1;
                    default: state_d = SHOW0;
                endcase
                // Outputs are computed from the next state so the display
                // changes on the same edge that samples the tick; the digit is
                // decoded straight from the input being latched on that edge.
                case (state_d)
                    SHOW0: begin
                        held0_d = digit0;
                        seg_d   = hex_decode(digit0);
                        an_d    = 2'b10;
                        frame_d = 1'b1;
                    end
                    SHOW1: begin
                        held1_d = digit1;
                        seg_d   = hex_decode(digit1);
                        an_d    = 2'b01;
                    end
                    default: begin
                        seg_d = 7'h7F;
                        an_d  = 2'b11;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BLANK1;
            cnt_q   <= '0;
            held0_q <= '0;
            held1_q <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 2'b11;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held0_q <= held0_d;
            held1_q <= held1_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
